// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for a shared single-port synchronous memory.
// Requester 0 is the CPU and requester 1 is the DMA/loader. Each transaction takes three cycles.
// The FSM walks through IDLE (grant), ACCESS (memory address/write) and DONE (completion pulse).
//
// Build option:
//   ARB_ROUND_ROBIN_EN defined   -> ties are resolved round-robin. A one-bit "last" pointer starts at 1.
//   ARB_ROUND_ROBIN_EN undefined -> requester 0 wins every tie. No pointer register is built.
//
// Ports:
//   clk, reset           single clock; synchronous active-high reset
//   req0/req1            access requests
//   we0/we1              1 = write, 0 = read
//   addr0/addr1          word addresses
//   wdata0/wdata1        write data
//   gnt0/gnt1            high while that requester owns the memory (ACCESS and DONE)
//   done0/done1          one-cycle completion pulse in DONE
//   rdata0/rdata1        per-requester read data, held until that requester's next read
//   busy                 high whenever the FSM is not in IDLE
//   mem_addr/mem_wdata   shared memory address and write data
//   mem_write            memory write strobe, only ever high in ACCESS
//   mem_rdata            memory read data, valid the cycle after mem_addr is presented
module mem_arbiter #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [BITS_ADDR-1:0] addr0,
    input  logic [BITS_ADDR-1:0] addr1,
    input  logic [BITS_DATA-1:0] wdata0,
    input  logic [BITS_DATA-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [BITS_DATA-1:0] rdata0,
    output logic [BITS_DATA-1:0] rdata1,
    output logic                 busy,
    output logic [BITS_ADDR-1:0] mem_addr,
    output logic [BITS_DATA-1:0] mem_wdata,
    output logic                 mem_write,
    input  logic [BITS_DATA-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   winner_q, winner_d;
    logic                   we_q, we_d;
    logic [BITS_ADDR-1:0]   addr_q, addr_d;
    logic [BITS_DATA-1:0]   wdata_q, wdata_d;
    logic [BITS_DATA-1:0]   rdata0_q, rdata0_d;
    logic [BITS_DATA-1:0]   rdata1_q, rdata1_d;

    logic reqAny;
    logic grant;
    logic pick;
    logic doneCycle;
    logic readDone;

    assign reqAny = req0 | req1;
    assign grant  = (state_q == IDLE) && reqAny;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On a tie the requester that was not granted last wins. A lone requester always wins.
    always_comb begin
        if (req0 && req1) begin
            pick = ~last_q;
        end else begin
            pick = ~req0;
        end
        last_d = grant ? pick : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is requesting.
    assign pick = ~req0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (reqAny) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The winner's command is frozen at the grant edge.
    // Later changes on its inputs cannot disturb the transaction in flight.
    always_comb begin
        winner_d = winner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (grant) begin
            winner_d = pick;
            if (pick) begin
                we_d    = we1;
                addr_d  = addr1;
                wdata_d = wdata1;
            end else begin
                we_d    = we0;
                addr_d  = addr0;
                wdata_d = wdata0;
            end
        end
        if ((state_q == DONE) && !we_q) begin
            if (winner_q) begin
                rdata1_d = mem_rdata;
            end else begin
                rdata0_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // A reset arriving in DONE suppresses the completion pulse.
    // mem_write is deliberately left ungated, because an ACCESS-cycle write lands on the same edge as the reset.
    assign doneCycle = (state_q == DONE) && !reset;
    assign readDone  = doneCycle && !we_q;

    assign busy      = (state_q != IDLE);
    assign gnt0      = busy && !winner_q;
    assign gnt1      = busy && winner_q;
    assign done0     = doneCycle && !winner_q;
    assign done1     = doneCycle && winner_q;
    assign mem_write = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Memory data arrives in DONE.
    // It is forwarded during that cycle so rdata is already valid alongside the done pulse.
    // It is also registered at the DONE edge so it holds afterwards.
    assign rdata0 = (readDone && !winner_q) ? mem_rdata : rdata0_q;
    assign rdata1 = (readDone && winner_q)  ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Each issued transaction pushes its expected result onto a scoreboard queue.
// The queue entry is popped and compared when the matching done pulse appears.
// The tie-ordering expectation follows ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, busy, mem_write;
    logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [31:0] data;
    } sbEntry_t;

    sbEntry_t    sbQueue[$];
    logic [31:0] refMem[logic [15:0]];

    logic [31:0] memArray[0:65535];
    logic        bdWe;
    logic [15:0] bdAddr;
    logic [31:0] bdData;

    mem_arbiter #(.BITS_DATA(32), .BITS_ADDR(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory with a backdoor used only while the arbiter is idle.
    always @(posedge clk) begin
        if (mem_write) begin
            memArray[mem_addr] <= mem_wdata;
        end else if (bdWe) begin
            memArray[bdAddr] <= bdData;
        end
        mem_rdata <= memArray[mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] refRead(input logic [15:0] a);
        return refMem.exists(a) ? refMem[a] : 32'h0;
    endfunction

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        refMem[a] = d;
        bdWe = 1'b1; bdAddr = a; bdData = d;
        @(posedge clk); #1;
        bdWe = 1'b0;
    endtask

    task automatic driveReq(input bit port, input bit r, input bit w, input logic [15:0] a, input logic [31:0] d);
        if (port) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // One complete transaction from a lone requester, with cycle-exact checks.
    // With lateChange set, the requester's address moves to lateAddr during ACCESS.
    task automatic applyStimulus(input bit port, input bit we, input logic [15:0] addr,
                                 input logic [31:0] data, input bit lateChange, input logic [15:0] lateAddr);
        sbEntry_t e;
        e.port = port; e.we = we; e.addr = addr;
        e.data = we ? data : refRead(addr);
        if (we) refMem[addr] = data;
        sbQueue.push_back(e);
        driveReq(port, 1'b1, we, addr, data);
        @(posedge clk); #1;
        if (lateChange) driveReq(port, 1'b1, we, lateAddr, data);
        @(negedge clk);
        checkOutput("accessGnt", 64'({gnt1, gnt0}), 64'(port ? 2 : 1));
        checkOutput("accessDone", 64'({done1, done0}), 64'd0);
        checkOutput("accessMemWrite", 64'(mem_write), 64'(we));
        checkOutput("accessMemAddr", 64'(mem_addr), 64'(addr));
        if (we) checkOutput("accessMemWdata", 64'(mem_wdata), 64'(data));
        @(posedge clk); #1;
        driveReq(port, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        checkOutput("doneGnt", 64'({gnt1, gnt0}), 64'(port ? 2 : 1));
        checkOutput("donePulse", 64'({done1, done0}), 64'(port ? 2 : 1));
        checkOutput("doneMemWrite", 64'(mem_write), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("idleAfter", 64'({busy, gnt1, gnt0, done1, done0, mem_write}), 64'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard: every done pulse consumes the oldest expected transaction.
    always @(negedge clk) begin
        sbEntry_t e;
        if (!reset && (done0 || done1)) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sbUnexpectedDone", 64'({done1, done0}), 64'd0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("sbDonePort", 64'({done1, done0}), 64'(e.port ? 2 : 1));
                if (!e.we) checkOutput("sbRdata", 64'(e.port ? rdata1 : rdata0), 64'(e.data));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit expPort[4];
        int doneSeen;

        reset = 1'b1; bdWe = 1'b0; bdAddr = '0; bdData = '0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstCtl", 64'({gnt0, gnt1, done0, done1, mem_write, busy}), 64'd0);
        checkOutput("rstMemAddr", 64'(mem_addr), 64'd0);
        checkOutput("rstMemWdata", 64'(mem_wdata), 64'd0);
        checkOutput("rstRdata0", 64'(rdata0), 64'd0);
        checkOutput("rstRdata1", 64'(rdata1), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset in the ACCESS cycle of a requester-1 read aborts it
        preload(16'h0040, 32'hCAFEF00D);
        driveReq(1'b1, 1'b1, 1'b0, 16'h0040, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("abortAccessGnt", 64'(gnt1), 64'd1);
        reset = 1'b1;
        driveReq(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abortIdle", 64'({busy, gnt1, done1}), 64'd0);
        checkOutput("abortRdata1", 64'(rdata1), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("abortNoDone", 64'({done1, done0}), 64'd0);
        checkOutput("abortRdata1Hold", 64'(rdata1), 64'd0);
        @(posedge clk); #1;

        // Single read by requester 0
        preload(16'h0010, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 16'h0010, 32'h0, 1'b0, 16'h0);
        checkOutput("readRdata0", 64'(rdata0), 64'hDEADBEEF);
        checkOutput("readRdata1", 64'(rdata1), 64'd0);

        // Requester-1 write, then read back from the top address
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 32'h12345678, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'hFFFF, 32'h0, 1'b0, 16'h0);
        checkOutput("wrRdRdata1", 64'(rdata1), 64'h12345678);
        checkOutput("wrRdRdata0Hold", 64'(rdata0), 64'hDEADBEEF);

        // Address change after grant is ignored
        preload(16'h0001, 32'h11111111);
        preload(16'h0002, 32'h22222222);
        applyStimulus(1'b0, 1'b0, 16'h0001, 32'h0, 1'b1, 16'h0002);
        checkOutput("lateAddrRdata0", 64'(rdata0), 64'h11111111);

        // Tie with both requests held continuously, starting from a reset pointer
        preload(16'h0100, 32'hA0A0A0A0);
        preload(16'h0200, 32'hB1B1B1B1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        expPort = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        expPort = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 4; k++) begin
            sbEntry_t e;
            e.port = expPort[k]; e.we = 1'b0;
            e.addr = expPort[k] ? 16'h0200 : 16'h0100;
            e.data = refRead(e.addr);
            sbQueue.push_back(e);
        end
        driveReq(1'b0, 1'b1, 1'b0, 16'h0100, 32'h0);
        driveReq(1'b1, 1'b1, 1'b0, 16'h0200, 32'h0);
        doneSeen = 0;
        for (int c = 0; c < 40 && doneSeen < 4; c++) begin
            @(negedge clk);
            if (done0 || done1) begin
                checkOutput("tieSpacing", 64'(c), 64'(2 + 3 * doneSeen));
                doneSeen++;
                if (doneSeen == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        checkOutput("tieCount", 64'(doneSeen), 64'd4);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idleQuiet", 64'({busy, mem_write, gnt0, gnt1, done0, done1}), 64'd0);
        end

        checkOutput("sbDrained", 64'(sbQueue.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
